mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM-stage controller between the EX/MEM and MEM/WB pipeline buffers. It turns the EX/MEM load/store controls into a request/acknowledge transaction on a variable-latency data-memory port. While an access is outstanding it freezes the upstream pipeline and sends bubbles into MEM/WB. It also produces the branch PC-select for the IF stage.

## Interface
- WAIT_LIMIT, 16: maximum BUSY cycles without `dmem_ack` before the access is aborted (1..255).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- exm_pc_branch  in  32  branch target from EX/MEM.
- exm_zf  in  1  ALU zero flag from EX/MEM.
- exm_alu  in  32  ALU result; this is the memory address.
- exm_wdata  in  32  store data.
- exm_rd  in  5  destination register.
- exm_wb  in  2  WB controls; [1]=RegWrite, [0]=MemtoReg.
- exm_m  in  3  M controls; [2]=Branch, [1]=MemRead, [0]=MemWrite.
- pc_src  out  1  selects `pc_branch` at the PC mux.
- pc_branch  out  32  forwarded copy of `exm_pc_branch`.
- pipe_stall  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM buffers.
- mem_rdata  out  32  registered load data, to MEM/WB.
- alu_pass  out  32  `exm_alu`, to MEM/WB.
- rd_pass  out  5  `exm_rd`, to MEM/WB.
- wb_pass  out  2  WB controls to MEM/WB; forced to 0 while stalled.
- dmem_req  out  1  registered memory request.
- dmem_we  out  1  write strobe; valid while `dmem_req` is high.
- dmem_addr  out  32  memory address.
- dmem_wdata  out  32  memory write data.
- dmem_ack  in  1  one-cycle transfer-complete pulse.
- dmem_rdata  in  32  read data; valid in the `dmem_ack` cycle.
- mem_err  out  1  sticky timeout flag.

## Operation
- `access` = `exm_m[1] | exm_m[0]`.
- The FSM has three states: IDLE, BUSY and DONE.

**FSM transitions**
- IDLE → BUSY when `access` is high. The counter clears.
- IDLE holds otherwise.
- BUSY → DONE on `dmem_ack`. Load data is captured into `mem_rdata`.
- BUSY → DONE on timeout: counter == WAIT_LIMIT−1 with no ack. `mem_err` sets, `mem_rdata` loads 0 and the request drops.
- BUSY holds otherwise and the counter increments.
- DONE → IDLE, unconditionally.

**Outputs**
- `pipe_stall` = (IDLE & `access`) | BUSY.
- DONE never stalls, so the upstream buffers advance at the end of DONE and IDLE then sees the next instruction.
- `dmem_req` is high exactly in BUSY and is driven from a flop.
- `dmem_we`, `dmem_addr` and `dmem_wdata` follow `exm_m[0]`, `exm_alu` and `exm_wdata`. They are stable while `dmem_req` is high, because EX/MEM is frozen.
- `wb_pass` = `pipe_stall` ? 2'b00 : `exm_wb`. This keeps the register file from repeatedly writing a stalled or incomplete result.
- `pc_src` = `exm_m[2]` & `exm_zf` & ~`pipe_stall`.
- `pc_branch`, `alu_pass` and `rd_pass` are combinational pass-throughs.
- `mem_rdata` changes only on ack or timeout capture. Non-memory instructions see the last captured value, which is don't-care because MemtoReg=0.

**Special cases**
- `exm_m[1]` and `exm_m[0]` both set: the access is performed as a write. `mem_rdata` captures 0 at ack, and `mem_err` is not set.
- `dmem_ack` outside BUSY is ignored.
- `mem_err` clears only on `rst`.

## Timing
- Reset state: FSM IDLE, counter 0, `mem_rdata` 0, `mem_err` 0, `dmem_req` 0.
- While `rst` is high: `pipe_stall`, `pc_src` and `wb_pass` are forced to 0.
- Reset asserted during BUSY drops `dmem_req` immediately (asynchronous); no ack is awaited.
- Memory access, with the instruction arriving in EX/MEM at cycle n:
  - n: IDLE, stall=1, no request.
  - n+1: BUSY, `dmem_req`=1.
  - With ack at n+1+k, DONE falls at n+2+k: stall=0, `mem_rdata` valid, `wb_pass`=`exm_wb`.
  - MEM/WB captures the result at the end of n+2+k.
  - Minimum stall is 2 cycles (k=0); each extra wait cycle adds one.
- Timeout: the request is held for exactly WAIT_LIMIT BUSY cycles, then DONE follows.
- Back-to-back memory instructions: IDLE in cycle n+3+k sees the new instruction and restarts the sequence. There is no request in the DONE cycle.
- Non-memory instructions: zero added latency, all outputs combinational.

## Test plan
- Reset: assert `rst` during BUSY → `dmem_req`=0 in the same cycle; after release, state IDLE, `mem_err`=0, `mem_rdata`=0.
- Zero-wait load: addr 0x100, ack in first BUSY cycle with `dmem_rdata`=0xCAFEF00D → stall high 2 cycles; `mem_rdata`=0xCAFEF00D and `wb_pass`=2'b11 in DONE.
- 3-wait store: addr 0x20, wdata 0x12345678, ack on 4th BUSY cycle → `dmem_we`=1 with stable addr/data for 4 cycles; `wb_pass`=0 throughout the stall.
- Timeout (WAIT_LIMIT=4), no ack → `dmem_req` high 4 cycles, then `mem_err`=1 stays set, `mem_rdata`=0.
- Branch with ZF=1 and target 0x40 → `pc_src`=1 and `pc_branch`=0x40 with no stall; same branch with ZF=0 → `pc_src`=0.
- Load, then store back-to-back, plus a spurious ack in IDLE → two separate transactions, the spurious ack ignored, no request in either DONE cycle.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory port between the MEM-stage controller (master) and the memory (slave).
// The request is level-held until a one-cycle ack; rdata is valid only with ack.
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage controller: turns EX/MEM load/store controls into a req/ack memory access,
// freezing the upstream pipeline and bubbling MEM/WB until the access completes.
module mem_access_stage #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                exm_pc_branch,
    input  logic                       exm_zf,
    input  logic [31:0]                exm_alu,
    input  logic [31:0]                exm_wdata,
    input  logic [4:0]                 exm_rd,
    input  logic [1:0]                 exm_wb,
    input  logic [2:0]                 exm_m,
    output logic                       pc_src,
    output logic [31:0]                pc_branch,
    output logic                       pipe_stall,
    output logic [31:0]                mem_rdata,
    output logic [31:0]                alu_pass,
    output logic [4:0]                 rd_pass,
    output logic [1:0]                 wb_pass,
    output logic                       mem_err,
    mem_access_stage_if.master         dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt_q;
    logic       req_q;
    logic       access;
    logic       timeout;

    assign access  = exm_m[1] | exm_m[0];
    assign timeout = (state_q == BUSY) && !dmem.ack && (wait_cnt_q == 8'(WAIT_LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == BUSY);
        end
    end

    always_comb begin
        state_d    = state_q;
        pipe_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    state_d    = BUSY;
                    pipe_stall = 1'b1;
                end
            end
            BUSY: begin
                pipe_stall = 1'b1;
                if (dmem.ack || timeout) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rst) begin
            pipe_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            wait_cnt_q <= '0;
        end else if (state_q == BUSY && state_d == BUSY) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end

    // A combined read+write is performed as a write, so the captured load data is 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata <= '0;
            mem_err   <= 1'b0;
        end else if (state_q == BUSY) begin
            if (dmem.ack) begin
                mem_rdata <= exm_m[0] ? 32'd0 : dmem.rdata;
            end else if (timeout) begin
                mem_rdata <= '0;
                mem_err   <= 1'b1;
            end
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = exm_m[0];
    assign dmem.addr  = exm_alu;
    assign dmem.wdata = exm_wdata;

    assign pc_src    = exm_m[2] & exm_zf & ~pipe_stall & ~rst;
    assign pc_branch = exm_pc_branch;
    assign alu_pass  = exm_alu;
    assign rd_pass   = exm_rd;
    assign wb_pass   = (pipe_stall || rst) ? 2'b00 : exm_wb;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus random instruction mix,
// checked against a per-instruction latency/result model.
module tb_mem_access_stage;

    localparam int WL = 4;

    logic        clk;
    logic        rst;
    logic [31:0] exm_pc_branch;
    logic        exm_zf;
    logic [31:0] exm_alu;
    logic [31:0] exm_wdata;
    logic [4:0]  exm_rd;
    logic [1:0]  exm_wb;
    logic [2:0]  exm_m;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic        pipe_stall;
    logic [31:0] mem_rdata;
    logic [31:0] alu_pass;
    logic [4:0]  rd_pass;
    logic [1:0]  wb_pass;
    logic        mem_err;

    mem_access_stage_if dmem_bus ();

    mem_access_stage #(.WAIT_LIMIT(WL)) dut (
        .clk           (clk),
        .rst           (rst),
        .exm_pc_branch (exm_pc_branch),
        .exm_zf        (exm_zf),
        .exm_alu       (exm_alu),
        .exm_wdata     (exm_wdata),
        .exm_rd        (exm_rd),
        .exm_wb        (exm_wb),
        .exm_m         (exm_m),
        .pc_src        (pc_src),
        .pc_branch     (pc_branch),
        .pipe_stall    (pipe_stall),
        .mem_rdata     (mem_rdata),
        .alu_pass      (alu_pass),
        .rd_pass       (rd_pass),
        .wb_pass       (wb_pass),
        .mem_err       (mem_err),
        .dmem          (dmem_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errCount   = 0;
    int          checkCount = 0;
    logic [31:0] expRdata   = '0;
    logic        expErr     = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Holds one instruction in EX/MEM for as long as the pipeline would, checking every cycle.
    // waits >= WL means the memory never acks, so the access must time out.
    task automatic applyStimulus(input logic [2:0] m, input logic [1:0] wb, input logic zf,
                                 input logic [31:0] target, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd,
                                 input int waits, input logic [31:0] rdata, input bit spurious);
        bit   isMem;
        bit   timedOut;
        int   n;
        logic stallE;
        logic reqE;
        isMem    = (m[1:0] != 2'b00);
        timedOut = isMem && (waits >= WL);
        if (!isMem)        n = 1;
        else if (timedOut) n = WL + 2;
        else               n = waits + 3;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            exm_m         = m;
            exm_wb        = wb;
            exm_zf        = zf;
            exm_pc_branch = target;
            exm_alu       = addr;
            exm_wdata     = wdata;
            exm_rd        = rd;
            dmem_bus.ack   = 1'b0;
            dmem_bus.rdata = $urandom;
            if (isMem && !timedOut && c == waits + 1) begin
                dmem_bus.ack   = 1'b1;
                dmem_bus.rdata = rdata;
            end else if (spurious && (c == 0 || c == n - 1)) begin
                dmem_bus.ack = 1'b1;
            end
            stallE = isMem && (c < n - 1);
            reqE   = isMem && (c > 0) && (c < n - 1);
            if (isMem && c == n - 1) begin
                expRdata = (timedOut || m[0]) ? 32'd0 : rdata;
                if (timedOut) expErr = 1'b1;
            end
            #2;
            checkOutput($sformatf("stall c%0d", c), {31'd0, pipe_stall}, {31'd0, stallE});
            checkOutput($sformatf("req c%0d", c), {31'd0, dmem_bus.req}, {31'd0, reqE});
            checkOutput($sformatf("wb_pass c%0d", c), {30'd0, wb_pass}, stallE ? 32'd0 : {30'd0, wb});
            checkOutput($sformatf("pc_src c%0d", c), {31'd0, pc_src}, {31'd0, m[2] & zf & ~stallE});
            checkOutput($sformatf("mem_rdata c%0d", c), mem_rdata, expRdata);
            checkOutput($sformatf("mem_err c%0d", c), {31'd0, mem_err}, {31'd0, expErr});
            if (reqE) begin
                checkOutput("dmem_we", {31'd0, dmem_bus.we}, {31'd0, m[0]});
                checkOutput("dmem_addr", dmem_bus.addr, addr);
                checkOutput("dmem_wdata", dmem_bus.wdata, wdata);
            end
            if (c == 0) begin
                checkOutput("pc_branch", pc_branch, target);
                checkOutput("alu_pass", alu_pass, addr);
                checkOutput("rd_pass", {27'd0, rd_pass}, {27'd0, rd});
            end
        end
    endtask

    task automatic resetDuringBusy();
        @(negedge clk);
        exm_m = 3'b010; exm_wb = 2'b11; exm_alu = 32'h300;
        dmem_bus.ack = 1'b0;
        #2;
        checkOutput("rst idle stall", {31'd0, pipe_stall}, 32'd1);
        @(negedge clk);
        #2;
        checkOutput("rst busy req", {31'd0, dmem_bus.req}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst req drop", {31'd0, dmem_bus.req}, 32'd0);
        checkOutput("rst stall", {31'd0, pipe_stall}, 32'd0);
        exm_m = 3'b100; exm_zf = 1'b1; exm_wb = 2'b11;
        #1;
        checkOutput("rst pc_src", {31'd0, pc_src}, 32'd0);
        checkOutput("rst wb_pass", {30'd0, wb_pass}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exm_m = 3'b000;
        expRdata = '0;
        expErr   = 1'b0;
        #2;
        checkOutput("post rst err", {31'd0, mem_err}, 32'd0);
        checkOutput("post rst rdata", mem_rdata, 32'd0);
        checkOutput("post rst req", {31'd0, dmem_bus.req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        exm_pc_branch = '0; exm_zf = 1'b0; exm_alu = '0; exm_wdata = '0;
        exm_rd = '0; exm_wb = '0; exm_m = '0;
        dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
        #1;
        checkOutput("reset req", {31'd0, dmem_bus.req}, 32'd0);
        checkOutput("reset stall", {31'd0, pipe_stall}, 32'd0);
        checkOutput("reset rdata", mem_rdata, 32'd0);
        checkOutput("reset err", {31'd0, mem_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(3'b010, 2'b11, 1'b0, 32'h0, 32'h100, 32'h0, 5'd3, 0, 32'hCAFEF00D, 1'b0);
        applyStimulus(3'b001, 2'b00, 1'b0, 32'h0, 32'h20, 32'h12345678, 5'd0, 3, 32'hDEADBEEF, 1'b0);
        applyStimulus(3'b100, 2'b00, 1'b1, 32'h40, 32'h0, 32'h0, 5'd0, 0, 32'h0, 1'b0);
        applyStimulus(3'b100, 2'b00, 1'b0, 32'h40, 32'h0, 32'h0, 5'd0, 0, 32'h0, 1'b0);
        applyStimulus(3'b010, 2'b11, 1'b0, 32'h0, 32'h44, 32'h0, 5'd7, WL, 32'h55AA55AA, 1'b0);
        applyStimulus(3'b010, 2'b11, 1'b0, 32'h0, 32'h80, 32'h0, 5'd9, 1, 32'h0BADF00D, 1'b1);
        applyStimulus(3'b001, 2'b00, 1'b0, 32'h0, 32'h84, 32'hA5A5A5A5, 5'd0, 0, 32'h11111111, 1'b1);
        applyStimulus(3'b011, 2'b11, 1'b0, 32'h0, 32'h88, 32'h77, 5'd2, 2, 32'h22222222, 1'b0);

        resetDuringBusy();

        for (int i = 0; i < 150; i++) begin
            logic [2:0] m;
            m[2] = 1'($urandom_range(0, 1));
            m[1:0] = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            applyStimulus(m, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                          5'($urandom), $urandom_range(0, WL), $urandom,
                          1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
